// File: rtl/tproc_time_dispatcher.sv
// Time-tagged dispatcher on the read side of the command FIFO: holds one head
// entry and issues its data when the local time counter reaches its timestamp.
module tproc_time_dispatcher #(
  parameter int unsigned DW  = 32,
  parameter int unsigned TW  = 48,
  parameter int unsigned LCW = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             time_rst_i,
  input  logic             time_updt_i,
  input  logic [TW-1:0]    time_dt_i,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic [TW+DW-1:0] fifo_dt_i,
  output logic             fifo_pop_o,
  output logic             port_vld_o,
  output logic [DW-1:0]    port_dt_o,
  output logic             head_vld_o,
  output logic             late_o,
  output logic [LCW-1:0]   late_cnt_o,
  output logic [TW-1:0]    time_abs_o
);

  typedef enum logic {HEAD_EMPTY, HEAD_LOADED} head_state_t;

  head_state_t   state_q, state_d;
  logic [TW-1:0] head_time_q;
  logic [DW-1:0] head_data_q;
  logic          gap_q;

  logic [TW-1:0] time_inc, time_nxt, due_diff, late_diff, fifo_time;
  logic          due, fire, fetch, entry_late;

  assign fifo_time  = fifo_dt_i[TW+DW-1:DW];
  assign head_vld_o = (state_q == HEAD_LOADED);

  always_comb begin
    time_inc = {{(TW-1){1'b0}}, en_i};
    time_nxt = time_abs_o;
    if (time_rst_i)       time_nxt = '0;
    else if (time_updt_i) time_nxt = time_abs_o + time_dt_i + time_inc;
    else if (en_i)        time_nxt = time_abs_o + time_inc;
  end

  // Wrap-safe comparisons: TW-bit differences with the MSB read as the sign.
  always_comb begin
    due_diff   = head_time_q - time_abs_o;
    due        = due_diff[TW-1] | (due_diff == '0);
    late_diff  = fifo_time - time_nxt;
    entry_late = late_diff[TW-1];
    fire       = head_vld_o & en_i & due & ~flush_i;
    fetch      = ~rst_i & (~head_vld_o | fire) & ~fifo_empty_i & ~gap_q & ~flush_i;
    fifo_pop_o = fetch;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i)    state_d = HEAD_EMPTY;
    else if (fetch) state_d = HEAD_LOADED;
    else if (fire)  state_d = HEAD_EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HEAD_EMPTY;
      head_time_q <= '0;
      head_data_q <= '0;
      gap_q       <= 1'b0;
      time_abs_o  <= '0;
      port_vld_o  <= 1'b0;
      port_dt_o   <= '0;
      late_o      <= 1'b0;
      late_cnt_o  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= fetch;
      time_abs_o <= time_nxt;
      port_vld_o <= fire;
      late_o     <= fetch & entry_late;
      if (fetch) begin
        head_time_q <= fifo_time;
        head_data_q <= fifo_dt_i[DW-1:0];
      end
      if (fire)
        port_dt_o <= head_data_q;
      if (fetch && entry_late && (late_cnt_o != '1))
        late_cnt_o <= late_cnt_o + {{(LCW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_tproc_time_dispatcher.sv
// Directed bench for tproc_time_dispatcher: a queue models the show-ahead FIFO,
// a negedge monitor logs pops, dispatches and late pulses.
module tb_tproc_time_dispatcher;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 48;

  logic             clk;
  logic             rst, en, time_rst, time_updt, flush, fifo_empty;
  logic [TW-1:0]    time_dt;
  logic [TW+DW-1:0] fifo_dt;

  logic             pop, port_vld, head_vld, late;
  logic [DW-1:0]    port_dt;
  logic [15:0]      late_cnt;
  logic [TW-1:0]    time_abs;

  logic             s_pop, s_port_vld, s_head_vld, s_late;
  logic [DW-1:0]    s_port_dt;
  logic [1:0]       s_late_cnt;
  logic [TW-1:0]    s_time_abs;

  tproc_time_dispatcher #(.DW(DW), .TW(TW), .LCW(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .time_rst_i(time_rst),
    .time_updt_i(time_updt), .time_dt_i(time_dt), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_dt_i(fifo_dt), .fifo_pop_o(pop),
    .port_vld_o(port_vld), .port_dt_o(port_dt), .head_vld_o(head_vld),
    .late_o(late), .late_cnt_o(late_cnt), .time_abs_o(time_abs)
  );

  tproc_time_dispatcher #(.DW(DW), .TW(TW), .LCW(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .time_rst_i(time_rst),
    .time_updt_i(time_updt), .time_dt_i(time_dt), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_dt_i(fifo_dt), .fifo_pop_o(s_pop),
    .port_vld_o(s_port_vld), .port_dt_o(s_port_dt), .head_vld_o(s_head_vld),
    .late_o(s_late), .late_cnt_o(s_late_cnt), .time_abs_o(s_time_abs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [TW+DW-1:0] fifo_q[$];
  logic [TW-1:0]    pop_t[$];
  logic [TW-1:0]    disp_t[$];
  logic [DW-1:0]    disp_d[$];
  int               late_n;
  logic             pop_l;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    pop_l = pop;
    if (pop) pop_t.push_back(time_abs);
    if (port_vld) begin
      disp_d.push_back(port_dt);
      disp_t.push_back(time_abs);
    end
    if (late) late_n++;
  end

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dt    = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] d);
    fifo_q.push_back({t, d});
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    if (pop_l && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; time_rst = 1'b0; time_updt = 1'b0;
    time_dt = '0; flush = 1'b0;
    fifo_q.delete();
    refresh();
    run(2);
    rst = 1'b0;
    pop_t.delete(); disp_t.delete(); disp_d.delete(); late_n = 0;
  endtask

  // Presets the counter with en low; returns in the cycle where time_abs == v.
  task automatic preset_time(input logic [TW-1:0] v);
    time_updt = 1'b1; time_dt = v;
    tick();
    time_updt = 1'b0; time_dt = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_time",     64'(time_abs), 64'd0);
    check("rst_port_vld", 64'(port_vld), 64'd0);
    check("rst_port_dt",  64'(port_dt),  64'd0);
    check("rst_head_vld", 64'(head_vld), 64'd0);
    check("rst_late",     64'(late),     64'd0);
    check("rst_late_cnt", 64'(late_cnt), 64'd0);
    check("rst_pop",      64'(pop),      64'd0);

    // Basic dispatch: t=10 fires when time_abs==10, seen at time 11
    en = 1'b1;
    push(48'd10, 32'hA5);
    run(20);
    check("b_pop_n",   64'(pop_t.size()),  64'd1);
    check("b_pop_t",   64'(pop_t[0]),      64'd0);
    check("b_disp_n",  64'(disp_d.size()), 64'd1);
    check("b_disp_d",  64'(disp_d[0]),     64'hA5);
    check("b_disp_t",  64'(disp_t[0]),     64'd11);
    check("b_late_n",  64'(late_n),        64'd0);
    check("b_head",    64'(head_vld),      64'd0);
    check("b_dt_held", 64'(port_dt),       64'hA5);

    // Back-to-back: t=7 is captured at time 7 into counter 8, the only late one
    do_reset();
    push(48'd5, 32'd1); push(48'd6, 32'd2); push(48'd7, 32'd3);
    en = 1'b1;
    run(15);
    begin
      logic [TW-1:0] ep[3] = '{48'd0, 48'd5, 48'd7};
      logic [TW-1:0] et[3] = '{48'd6, 48'd7, 48'd9};
      check("bb_pop_n",  64'(pop_t.size()),  64'd3);
      check("bb_disp_n", 64'(disp_d.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("bb_pop_t%0d", i),  64'(pop_t[i]),  64'(ep[i]));
        check($sformatf("bb_disp_d%0d", i), 64'(disp_d[i]), 64'(i + 1));
        check($sformatf("bb_disp_t%0d", i), 64'(disp_t[i]), 64'(et[i]));
      end
    end
    check("bb_late_n",   64'(late_n),     64'd1);
    check("bb_late_cnt", 64'(late_cnt),   64'd1);
    check("bb_sat_cnt",  64'(s_late_cnt), 64'd1);

    // Late entry: t=40 captured at time 100
    do_reset();
    preset_time(48'd100);
    check("l_preset", 64'(time_abs), 64'd100);
    en = 1'b1;
    push(48'd40, 32'h7);
    run(6);
    check("l_pop_t",    64'(pop_t[0]),      64'd100);
    check("l_late_n",   64'(late_n),        64'd1);
    check("l_late_cnt", 64'(late_cnt),      64'd1);
    check("l_disp_n",   64'(disp_d.size()), 64'd1);
    check("l_disp_d",   64'(disp_d[0]),     64'h7);
    check("l_disp_t",   64'(disp_t[0]),     64'd102);

    // Wrap-around: counter at 2^48-3, entry t=2 is in the future
    do_reset();
    preset_time(48'hFFFF_FFFF_FFFD);
    check("w_preset", 64'(time_abs), 64'h0000_FFFF_FFFF_FFFD);
    en = 1'b1;
    push(48'd2, 32'h55);
    run(10);
    check("w_pop_t",  64'(pop_t[0]),      64'h0000_FFFF_FFFF_FFFD);
    check("w_late_n", 64'(late_n),        64'd0);
    check("w_disp_n", 64'(disp_d.size()), 64'd1);
    check("w_disp_d", 64'(disp_d[0]),     64'h55);
    check("w_disp_t", 64'(disp_t[0]),     64'd3);

    // Flush/enable: freeze at 20, flush the t=50 head, next entry fetched
    do_reset();
    en = 1'b1;
    push(48'd50, 32'hBB); push(48'd70, 32'hCC);
    run(20);
    en = 1'b0;
    run(10);
    check("f_frozen", 64'(time_abs), 64'd20);
    check("f_head1",  64'(head_vld), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("f_head0",  64'(head_vld), 64'd0);
    check("f_refill", 64'(pop),      64'd1);
    run(10);
    check("f_head2",    64'(head_vld),      64'd1);
    check("f_frozen2",  64'(time_abs),      64'd20);
    check("f_no_disp",  64'(disp_d.size()), 64'd0);
    en = 1'b1;
    run(60);
    check("f_pop_n",  64'(pop_t.size()),  64'd2);
    check("f_pop_t1", 64'(pop_t[1]),      64'd20);
    check("f_disp_n", 64'(disp_d.size()), 64'd1);
    check("f_disp_d", 64'(disp_d[0]),     64'hCC);
    check("f_disp_t", 64'(disp_t[0]),     64'd71);
    check("f_late_n", 64'(late_n),        64'd0);

    // Saturation: 5 late entries, 1 per 2 cycles
    do_reset();
    preset_time(48'd100);
    en = 1'b1;
    for (int i = 1; i <= 5; i++) push(48'(i), 32'(10 + i));
    run(14);
    check("s_pop_n",  64'(pop_t.size()),  64'd5);
    check("s_disp_n", 64'(disp_d.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s_pop_t%0d", i),  64'(pop_t[i]),  64'(100 + 2 * i));
      check($sformatf("s_disp_d%0d", i), 64'(disp_d[i]), 64'(11 + i));
    end
    check("s_late_n",   64'(late_n),     64'd5);
    check("s_late_cnt", 64'(late_cnt),   64'd5);
    check("s_sat_cnt",  64'(s_late_cnt), 64'd3);

    // Reset with the head loaded
    push(48'd1000, 32'hEE); push(48'd2000, 32'hFF);
    begin
      int k = 0;
      while (!head_vld && k < 5) begin tick(); k++; end
    end
    check("r_head_pre", 64'(head_vld), 64'd1);
    rst = 1'b1;
    tick();
    check("r_time",       64'(time_abs),   64'd0);
    check("r_port_vld",   64'(port_vld),   64'd0);
    check("r_port_dt",    64'(port_dt),    64'd0);
    check("r_head",       64'(head_vld),   64'd0);
    check("r_late",       64'(late),       64'd0);
    check("r_late_cnt",   64'(late_cnt),   64'd0);
    check("r_pop",        64'(pop),        64'd0);
    check("r_sat_cnt",    64'(s_late_cnt), 64'd0);
    check("r_sat_dt",     64'(s_port_dt),  64'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
